// File: rtl/fetch_queue_if.sv
// Fetch-stage bus bundle: the instruction-memory read port and the
// decode-side output handshake of fetch_queue.
//
// Handshake rules (decode side): a word moves when out_valid & out_ready
// are both 1 at a rising clk edge. Once out_valid rises it stays 1, and
// out_instr/out_pc stay constant, until that word is taken or flushed by a
// redirect or reset. out_ready may change in any cycle and may depend on
// out_valid. The imem side has no handshake: imem_rdata is taken exactly one
// cycle after a cycle with imem_rd=1.
//
// Signals (directions as seen by the fetch stage, modport master):
//   imem_addr  out PC_W     read word address
//   imem_rd    out 1        read strobe
//   imem_rdata in  INSTR_W  read data, one cycle after imem_rd
//   out_valid  out 1        head of queue valid
//   out_instr  out INSTR_W  head instruction
//   out_pc     out PC_W     PC of head instruction
//   out_ready  in  1        decode accepts head
interface fetch_queue_if #(
   parameter int PC_W    = 19,
   parameter int INSTR_W = 32
);
   logic [PC_W-1:0]    imem_addr;
   logic               imem_rd;
   logic [INSTR_W-1:0] imem_rdata;
   logic               out_valid;
   logic [INSTR_W-1:0] out_instr;
   logic [PC_W-1:0]    out_pc;
   logic               out_ready;

   modport master (
      output imem_addr, imem_rd, out_valid, out_instr, out_pc,
      input  imem_rdata, out_ready
   );

   modport slave (
      input  imem_addr, imem_rd, out_valid, out_instr, out_pc,
      output imem_rdata, out_ready
   );
endinterface

// File: rtl/fetch_queue.sv
// Fetch stage: owns the fetch PC, issues one-cycle-latency reads to the
// instruction memory and buffers returned words with their PCs in a
// DEPTH-entry FIFO presented to decode over a valid/ready handshake.
// A redirect loads a new PC and discards queued and in-flight words.
//
// Ports:
//   clk             clock, all state updates on rising edge
//   rstn            synchronous reset, active low
//   fetch_en        allows new reads to be issued; queue drains regardless
//   redirect_valid  load redirect_pc, flush queue and in-flight read
//   redirect_pc     new fetch PC
//   pc              current fetch PC (equals imem_addr)
//   bus             imem read port and decode handshake (fetch_queue_if)
//
// DEPTH must be a power of two and at least 2.
module fetch_queue #(
   parameter int              PC_W     = 19,
   parameter int              INSTR_W  = 32,
   parameter int              DEPTH    = 2,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            fetch_en,
   input  logic            redirect_valid,
   input  logic [PC_W-1:0] redirect_pc,
   output logic [PC_W-1:0] pc,
   fetch_queue_if.master   bus
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int NW = AW + 1;   // occupancy counter, holds 0..DEPTH
   localparam int CW = AW + 2;   // credit sum, holds 0..DEPTH+1

   // fetch PC and the single outstanding read
   logic [PC_W-1:0]    pc_q;
   logic               inflight_q;
   logic [PC_W-1:0]    inflight_pc_q;

   // FIFO storage
   logic [INSTR_W-1:0] instr_mem [DEPTH];
   logic [PC_W-1:0]    pc_mem    [DEPTH];
   logic [AW-1:0]      rd_ptr;
   logic [AW-1:0]      wr_ptr;
   logic [NW-1:0]      count;

   // last presented head, shown again while the queue is empty
   logic [INSTR_W-1:0] hold_instr_q;
   logic [PC_W-1:0]    hold_pc_q;

   logic               head_valid;
   logic               pop;
   logic               push;
   logic               issue;
   logic [CW-1:0]      credit_used;

   always_comb begin
      head_valid  = (count != '0);
      pop         = head_valid & bus.out_ready;
      // Every issued read reserves a slot, so the word that returns next
      // cycle always finds room. A pop this cycle frees a slot early.
      credit_used = {1'b0, count} + CW'(inflight_q) - CW'(pop);
      issue       = rstn & fetch_en & ~redirect_valid & (credit_used < CW'(DEPTH));
      // A word returning in a redirect cycle belongs to the old stream.
      push        = inflight_q & ~redirect_valid;
   end

   assign bus.imem_rd   = issue;
   assign bus.imem_addr = pc_q;
   assign pc            = pc_q;
   assign bus.out_valid = head_valid;
   assign bus.out_instr = head_valid ? instr_mem[rd_ptr] : hold_instr_q;
   assign bus.out_pc    = head_valid ? pc_mem[rd_ptr]    : hold_pc_q;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         pc_q          <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
         rd_ptr        <= '0;
         wr_ptr        <= '0;
         count         <= '0;
         hold_instr_q  <= '0;
         hold_pc_q     <= '0;
      end else begin
         hold_instr_q <= bus.out_instr;
         hold_pc_q    <= bus.out_pc;
         // issue is already 0 in a redirect cycle, which also kills the tag
         inflight_q   <= issue;
         if (issue) begin
            inflight_pc_q <= pc_q;
         end

         if (redirect_valid) begin
            pc_q   <= redirect_pc;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
         end else begin
            if (issue) begin
               pc_q <= pc_q + PC_W'(1);
            end
            if (push) begin
               instr_mem[wr_ptr] <= bus.imem_rdata;
               pc_mem[wr_ptr]    <= inflight_pc_q;
               wr_ptr            <= wr_ptr + AW'(1);
            end
            if (pop) begin
               rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + NW'(push) - NW'(pop);
         end
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: random and directed stimulus, an imem responder
// returning mem[a] = a + 0x100, and a reference model that tracks the fetch
// stream as a list of issued-but-undelivered PCs.
module tb_fetch_queue;

   localparam int              PC_W     = 19;
   localparam int              INSTR_W  = 32;
   localparam int              DEPTH    = 2;
   localparam logic [PC_W-1:0] RESET_PC = '0;
   localparam int              EW       = INSTR_W + PC_W;

   // ---------------- clock / reset / DUT ----------------
   logic            clk = 1'b0;
   logic            rstn;
   logic            fetch_en;
   logic            redirect_valid;
   logic [PC_W-1:0] redirect_pc;
   logic [PC_W-1:0] pc;

   fetch_queue_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

   fetch_queue #(
      .PC_W(PC_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
   ) dut (
      .clk(clk),
      .rstn(rstn),
      .fetch_en(fetch_en),
      .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc),
      .pc(pc),
      .bus(bus.master)
   );

   always #5 clk = ~clk;

   // ---------------- bookkeeping ----------------
   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [INSTR_W-1:0] mem_word(input logic [PC_W-1:0] a);
      return INSTR_W'(a) + 32'h100;
   endfunction

   // ---------------- imem responder ----------------
   logic            rd_s;
   logic [PC_W-1:0] addr_s;

   always begin
      @(negedge clk);
      rd_s   = bus.imem_rd;
      addr_s = bus.imem_addr;
      @(posedge clk);
      #1;
      // garbage when nothing was read, so a mistimed capture shows up
      bus.imem_rdata = (rd_s === 1'b1) ? mem_word(addr_s) : INSTR_W'($urandom);
   end

   // ---------------- reference model + scoreboard ----------------
   // exp_q holds {instr, pc} for every read issued and not yet delivered
   // or flushed; its size is the credit in use.
   logic [EW-1:0]   exp_q[$];
   logic [PC_W-1:0] model_pc    = RESET_PC;
   logic            expect_idle = 1'b0;
   logic            prev_stall  = 1'b0;
   logic            hs;
   logic            exp_issue;
   int              size_before;
   logic [EW-1:0]   e;

   always @(negedge clk) begin
      if (expect_idle) check("idle_after_flush", bus.out_valid, 1'b0);
      if (prev_stall)  check("valid_held", bus.out_valid, 1'b1);

      check("pc_track", pc, model_pc);

      hs          = rstn && (bus.out_valid === 1'b1) && (bus.out_ready === 1'b1);
      size_before = exp_q.size();
      if (hs) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL deliver_spurious: got pc %0h expected no word at %0t", bus.out_pc, $time);
         end else begin
            e = exp_q.pop_front();
            check("deliver_pc", bus.out_pc, e[PC_W-1:0]);
            check("deliver_instr", bus.out_instr, e[EW-1:PC_W]);
         end
      end

      exp_issue = rstn && fetch_en && !redirect_valid && ((size_before - int'(hs)) < DEPTH);
      check("imem_rd", bus.imem_rd, exp_issue);
      if (exp_issue && bus.imem_rd === 1'b1) begin
         check("imem_addr", bus.imem_addr, model_pc);
         exp_q.push_back({mem_word(model_pc), model_pc});
         model_pc = model_pc + PC_W'(1);
      end

      if (!rstn) begin
         exp_q.delete();
         model_pc    = RESET_PC;
         expect_idle = 1'b1;
         prev_stall  = 1'b0;
      end else if (redirect_valid) begin
         exp_q.delete();
         model_pc    = redirect_pc;
         expect_idle = 1'b1;
         prev_stall  = 1'b0;
      end else begin
         expect_idle = 1'b0;
         prev_stall  = (bus.out_valid === 1'b1) && !bus.out_ready;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Redirect for one cycle with fetch_en=1, out_ready=1 afterwards;
   // checks the flush bubble and the first word from the new PC.
   task automatic redirect_check(input logic [PC_W-1:0] target);
      redirect_valid = 1'b1;
      redirect_pc    = target;
      tick();
      redirect_valid = 1'b0;
      fetch_en       = 1'b1;
      out_ready_set(1'b1);
      @(negedge clk);
      check("redir_r1_valid", bus.out_valid, 1'b0);
      check("redir_r1_rd", bus.imem_rd, 1'b1);
      tick();
      tick();
      @(negedge clk);
      check("redir_r3_valid", bus.out_valid, 1'b1);
      check("redir_r3_pc", bus.out_pc, target);
      tick();
   endtask

   task automatic out_ready_set(input logic v);
      bus.out_ready = v;
   endtask

   logic [PC_W-1:0] held_pc;

   initial begin
      rstn           = 1'b0;
      fetch_en       = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      bus.out_ready  = 1'b0;
      bus.imem_rdata = '0;
      repeat (3) tick();
      @(negedge clk);
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_pc", pc, RESET_PC);
      check("rst_out_pc", bus.out_pc, '0);
      check("rst_out_instr", bus.out_instr, '0);
      check("rst_imem_rd", bus.imem_rd, 1'b0);
      tick();

      // streaming from reset: word for pc i shows up in cycle i+2, no gaps
      rstn          = 1'b1;
      fetch_en      = 1'b1;
      bus.out_ready = 1'b1;
      tick();
      tick();
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("t1_valid", bus.out_valid, 1'b1);
         check("t1_pc", bus.out_pc, PC_W'(i));
         check("t1_instr", bus.out_instr, mem_word(PC_W'(i)));
         tick();
      end

      // decode stall: queue fills, issue stops, then drains in order
      bus.out_ready = 1'b0;
      repeat (10) tick();
      @(negedge clk);
      check("t2_full_valid", bus.out_valid, 1'b1);
      check("t2_no_issue", bus.imem_rd, 1'b0);
      tick();
      bus.out_ready = 1'b1;
      repeat (6) tick();

      // redirect with the queue full
      bus.out_ready = 1'b0;
      repeat (4) tick();
      redirect_check(PC_W'(32'h40));

      // redirect mid-stream, handshake completing in the redirect cycle
      repeat (5) tick();
      redirect_check(PC_W'(32'h123));

      // PC wrap at the top of the address space
      redirect_check(PC_W'(32'h7FFFE));
      @(negedge clk);
      check("t5_wrap_pc1", bus.out_pc, PC_W'(32'h7FFFF));
      tick();
      @(negedge clk);
      check("t5_wrap_pc0", bus.out_pc, PC_W'(0));
      tick();

      // fetch_en low: PC holds, queue drains
      fetch_en = 1'b0;
      tick();
      held_pc = model_pc;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("t5_pc_hold", pc, held_pc);
         tick();
      end
      @(negedge clk);
      check("t5_drained", bus.out_valid, 1'b0);
      tick();

      // reset with queue occupied and a read in flight
      fetch_en      = 1'b1;
      bus.out_ready = 1'b0;
      repeat (5) tick();
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      @(negedge clk);
      check("t6_valid", bus.out_valid, 1'b0);
      check("t6_pc", pc, RESET_PC);
      check("t6_out_pc", bus.out_pc, '0);
      tick();
      bus.out_ready = 1'b1;
      repeat (6) tick();

      // random traffic
      for (int i = 0; i < 600; i++) begin
         fetch_en       = ($urandom_range(0, 9) != 0);
         bus.out_ready  = ($urandom_range(0, 3) != 0);
         redirect_valid = ($urandom_range(0, 19) == 0);
         redirect_pc    = PC_W'($urandom);
         rstn           = ($urandom_range(0, 59) != 0);
         tick();
      end

      // drain everything still owed
      rstn           = 1'b1;
      redirect_valid = 1'b0;
      fetch_en       = 1'b0;
      bus.out_ready  = 1'b1;
      repeat (6) tick();
      @(negedge clk);
      #1;
      check("final_queue_empty", exp_q.size(), 0);
      check("final_out_valid", bus.out_valid, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
